// File: rtl/mem_responder.sv
// mem_responder: word RAM behind the MAR/MDR path with wait states and a one-cycle ready pulse
module mem_responder #(
  parameter int REG_SIZE    = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                read,
  input  logic                write,
  input  logic [REG_SIZE-1:0] mar_output,
  input  logic [REG_SIZE-1:0] mdr_output,
  output logic [REG_SIZE-1:0] mem_data_out,
  output logic                mem_ready,
  output logic                mem_err,
  output logic                busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [REG_SIZE-1:0]   r_wdata;
  logic [REG_SIZE-1:0]   r_ram [2**ADDR_WIDTH];
  logic                  w_req;
  logic                  w_bad;
  assign w_req = read ^ write;
  assign w_bad = (read & write) | (w_req & (|mar_output[REG_SIZE-1:ADDR_WIDTH]));
  // Control FSM: latches the request in IDLE, counts wait states, performs the read and pulses ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      mem_data_out <= '0;
      mem_ready    <= 1'b0;
      mem_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_bad) begin
            r_state   <= S_DONE;
            mem_ready <= 1'b1;
            mem_err   <= 1'b1;
            busy      <= 1'b1;
          end else if (w_req) begin
            r_state <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            r_cnt   <= 4'(WAIT_STATES);
            r_wr    <= write;
            r_addr  <= mar_output[ADDR_WIDTH-1:0];
            r_wdata <= mdr_output;
            busy    <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!r_wr) mem_data_out <= r_ram[r_addr];
          r_state   <= S_DONE;
          mem_ready <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          mem_ready <= 1'b0;
          mem_err   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
  // RAM write port; contents survive reset, and an aborted access never reaches ACCESS
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_wr) r_ram[r_addr] <= r_wdata;
  end
endmodule
